// File: rtl/branch_pre.sv
// -----------------------------------------------------------------------------
// branch_pre
//
// Decode-stage branch/jump predictor for the ysyx_22041752 core.
//   - 2^BHT_IDX-entry direct-mapped BHT of 2-bit saturating counters
//     predicts conditional branch direction.
//   - 2^BTB_IDX-entry direct-mapped BTB predicts jalr targets.
//   - Two free-running 32-bit statistics counters (resolutions, mispredicts).
//   - Optional 4-entry return address stack, enabled by defining
//     YSYX_22041752_RAS_EN (adds ports ds_call / ds_ret).
//
// Lookups are purely combinational from the registered tables. Training
// comes from the execute stage: es_valid is a one-cycle qualifier per
// resolved instruction, and every write lands on the next rising clk edge.
// There is no bypass, so a lookup in the same cycle as a write to the same
// entry returns the old contents.
//
// Ports:
//   clk, reset             core clock, asynchronous active-high reset
//   ds_valid, ds_ready_go  decode holds a valid instr / instr leaves decode
//   ds_pc                  decode pc
//   ds_branch, ds_jalr     decode instruction class
//   ds_call, ds_ret        (RAS build only) call / return hints
//   br_taken_pre           predicted direction for decode branch
//   jt_pre, jt_hit         predicted jalr target and BTB/RAS hit
//   es_valid               one-cycle pulse per resolved instruction
//   es_pc, es_branch,
//   es_jalr                execute pc and class
//   b_taken_real, bj_addr  real outcome and computed target
//   pre_error              execute-detected mispredict
//   res_cnt, err_cnt       resolution / mispredict counters (wrap at 2^32)
// -----------------------------------------------------------------------------
module branch_pre #(
    parameter int PC_WD   = 32,
    parameter int BHT_IDX = 6,
    parameter int BTB_IDX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds_valid,
    input  logic             ds_ready_go,
    input  logic [PC_WD-1:0] ds_pc,
    input  logic             ds_branch,
    input  logic             ds_jalr,
`ifdef YSYX_22041752_RAS_EN
    input  logic             ds_call,
    input  logic             ds_ret,
`endif
    output logic             br_taken_pre,
    output logic [PC_WD-1:0] jt_pre,
    output logic             jt_hit,
    input  logic             es_valid,
    input  logic [PC_WD-1:0] es_pc,
    input  logic             es_branch,
    input  logic             es_jalr,
    input  logic             b_taken_real,
    input  logic [PC_WD-1:0] bj_addr,
    input  logic             pre_error,
    output logic [31:0]      res_cnt,
    output logic [31:0]      err_cnt
);

    localparam int BHT_N = 1 << BHT_IDX;
    localparam int BTB_N = 1 << BTB_IDX;
    localparam int TAG_W = PC_WD - BTB_IDX - 2;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [1:0]       r_bht       [BHT_N];
    logic             r_btb_valid [BTB_N];
    logic [TAG_W-1:0] r_btb_tag   [BTB_N];
    logic [PC_WD-1:0] r_btb_tgt   [BTB_N];
    logic [31:0]      r_res_cnt;
    logic [31:0]      r_err_cnt;

    // -------------------------------------------------------------------------
    // Decode-side lookup
    // -------------------------------------------------------------------------
    logic [BHT_IDX-1:0] w_ds_bht_idx;
    logic [BTB_IDX-1:0] w_ds_btb_idx;
    logic [TAG_W-1:0]   w_ds_tag;
    logic [PC_WD-1:0]   w_ds_pc_plus4;
    logic               w_btb_hit;

    assign w_ds_bht_idx  = ds_pc[BHT_IDX+1:2];
    assign w_ds_btb_idx  = ds_pc[BTB_IDX+1:2];
    assign w_ds_tag      = ds_pc[PC_WD-1:BTB_IDX+2];
    assign w_ds_pc_plus4 = ds_pc + PC_WD'(4);
    assign w_btb_hit     = r_btb_valid[w_ds_btb_idx] &&
                           (r_btb_tag[w_ds_btb_idx] == w_ds_tag);

    // MSB of the 2-bit counter is the taken prediction. The counters are
    // forced to weakly-not-taken asynchronously, so this is 0 during reset.
    assign br_taken_pre = ds_valid & ds_branch & r_bht[w_ds_bht_idx][1];

    // -------------------------------------------------------------------------
    // Execute-side training controls
    // -------------------------------------------------------------------------
    logic [BHT_IDX-1:0] w_es_bht_idx;
    logic [BTB_IDX-1:0] w_es_btb_idx;
    logic [TAG_W-1:0]   w_es_tag;
    logic               w_bht_we;
    logic               w_btb_we;
    logic [1:0]         w_bht_cur;
    logic [1:0]         w_bht_next;

    assign w_es_bht_idx = es_pc[BHT_IDX+1:2];
    assign w_es_btb_idx = es_pc[BTB_IDX+1:2];
    assign w_es_tag     = es_pc[PC_WD-1:BTB_IDX+2];
    assign w_bht_we     = es_valid & es_branch;
    // A resolution flagged as both branch and jalr only trains the BHT.
    assign w_btb_we     = es_valid & es_jalr & ~es_branch;
    assign w_bht_cur    = r_bht[w_es_bht_idx];

    // Saturating 2-bit counter step.
    always_comb begin
        w_bht_next = w_bht_cur;
        if (b_taken_real) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_next = w_bht_cur + 2'b01;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_next = w_bht_cur - 2'b01;
            end
        end
    end

    // -------------------------------------------------------------------------
    // BHT update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_we) begin
            r_bht[w_es_bht_idx] <= w_bht_next;
        end
    end

    // -------------------------------------------------------------------------
    // BTB update: valid bits are reset; tag/target are only meaningful while
    // the valid bit is set, so they carry no reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_valid[i] <= 1'b0;
            end
        end else if (w_btb_we) begin
            r_btb_valid[w_es_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_btb_we) begin
            r_btb_tag[w_es_btb_idx] <= w_es_tag;
            r_btb_tgt[w_es_btb_idx] <= bj_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters (natural 32-bit wrap)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_cnt <= 32'd0;
            r_err_cnt <= 32'd0;
        end else begin
            if (es_valid & (es_branch | es_jalr)) begin
                r_res_cnt <= r_res_cnt + 32'd1;
            end
            if (es_valid & pre_error) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign res_cnt = r_res_cnt;
    assign err_cnt = r_err_cnt;

`ifdef YSYX_22041752_RAS_EN
    // -------------------------------------------------------------------------
    // Return address stack: circular buffer of 4 entries. r_ras_ptr is the
    // next push slot, so top-of-stack lives at r_ras_ptr-1. r_ras_cnt
    // saturates at 4; a push onto a full stack silently overwrites the
    // oldest entry because the pointer wraps onto it.
    // -------------------------------------------------------------------------
    logic [PC_WD-1:0] r_ras [4];
    logic [1:0]       r_ras_ptr;
    logic [2:0]       r_ras_cnt;
    logic [1:0]       w_ras_top_idx;
    logic             w_ras_nonempty;
    logic             w_ras_push;
    logic             w_ras_pop;
    logic [PC_WD-1:0] w_ras_top;

    assign w_ras_top_idx  = r_ras_ptr - 2'd1;
    assign w_ras_nonempty = (r_ras_cnt != 3'd0);
    assign w_ras_top      = r_ras[w_ras_top_idx];
    assign w_ras_push     = ds_valid & ds_ready_go & ds_call;
    assign w_ras_pop      = ds_valid & ds_ready_go & ds_ret & w_ras_nonempty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ras_ptr <= 2'd0;
            r_ras_cnt <= 3'd0;
        end else if (w_ras_push & ~w_ras_pop) begin
            r_ras_ptr <= r_ras_ptr + 2'd1;
            if (r_ras_cnt != 3'd4) begin
                r_ras_cnt <= r_ras_cnt + 3'd1;
            end
        end else if (w_ras_pop & ~w_ras_push) begin
            r_ras_ptr <= r_ras_ptr - 2'd1;
            r_ras_cnt <= r_ras_cnt - 3'd1;
        end
    end

    // Push+pop together replaces the top entry in place.
    always_ff @(posedge clk) begin
        if (w_ras_push & w_ras_pop) begin
            r_ras[w_ras_top_idx] <= w_ds_pc_plus4;
        end else if (w_ras_push) begin
            r_ras[r_ras_ptr] <= w_ds_pc_plus4;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // jalr target selection
    // -------------------------------------------------------------------------
    always_comb begin
        jt_hit = 1'b0;
        jt_pre = '0;
        if (reset) begin
            // While held in reset the tables are empty: report a miss.
            if (ds_jalr) begin
                jt_pre = w_ds_pc_plus4;
            end
        end else if (ds_valid & ds_jalr) begin
`ifdef YSYX_22041752_RAS_EN
            if (ds_ret & w_ras_nonempty) begin
                jt_hit = 1'b1;
                jt_pre = w_ras_top;
            end else
`endif
            if (w_btb_hit) begin
                jt_hit = 1'b1;
                jt_pre = r_btb_tgt[w_ds_btb_idx];
            end else begin
                jt_pre = w_ds_pc_plus4;
            end
        end
    end

    // Bits that are intentionally not consumed in every build.
    logic w_unused_ok;
    assign w_unused_ok = ds_ready_go ^ es_pc[0] ^ es_pc[1];

endmodule

// File: tb/tb_branch_pre.sv
module tb_branch_pre;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_valid, ds_ready_go, ds_branch, ds_jalr;
    logic [31:0] ds_pc;
`ifdef YSYX_22041752_RAS_EN
    logic        ds_call, ds_ret;
`endif
    logic        br_taken_pre, jt_hit;
    logic [31:0] jt_pre;
    logic        es_valid, es_branch, es_jalr, b_taken_real, pre_error;
    logic [31:0] es_pc, bj_addr;
    logic [31:0] res_cnt, err_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    branch_pre dut (
        .clk          (clk),
        .reset        (reset),
        .ds_valid     (ds_valid),
        .ds_ready_go  (ds_ready_go),
        .ds_pc        (ds_pc),
        .ds_branch    (ds_branch),
        .ds_jalr      (ds_jalr),
`ifdef YSYX_22041752_RAS_EN
        .ds_call      (ds_call),
        .ds_ret       (ds_ret),
`endif
        .br_taken_pre (br_taken_pre),
        .jt_pre       (jt_pre),
        .jt_hit       (jt_hit),
        .es_valid     (es_valid),
        .es_pc        (es_pc),
        .es_branch    (es_branch),
        .es_jalr      (es_jalr),
        .b_taken_real (b_taken_real),
        .bj_addr      (bj_addr),
        .pre_error    (pre_error),
        .res_cnt      (res_cnt),
        .err_cnt      (err_cnt)
    );

    // ---------------------------------------------------------- check task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic es_pulse(input logic [31:0] pc, input logic br, input logic jr,
                            input logic tk, input logic [31:0] addr, input logic err);
        es_valid     = 1'b1;
        es_pc        = pc;
        es_branch    = br;
        es_jalr      = jr;
        b_taken_real = tk;
        bj_addr      = addr;
        pre_error    = err;
        step();
        es_valid  = 1'b0;
        es_branch = 1'b0;
        es_jalr   = 1'b0;
        pre_error = 1'b0;
    endtask

    task automatic ds_look(input logic v, input logic [31:0] pc, input logic br, input logic jr);
        ds_valid  = v;
        ds_pc     = pc;
        ds_branch = br;
        ds_jalr   = jr;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // --------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        reset = 1'b1;
        ds_valid = 0; ds_ready_go = 1; ds_pc = 0; ds_branch = 0; ds_jalr = 0;
`ifdef YSYX_22041752_RAS_EN
        ds_call = 0; ds_ret = 0;
`endif
        es_valid = 0; es_pc = 0; es_branch = 0; es_jalr = 0;
        b_taken_real = 0; bj_addr = 0; pre_error = 0;

        // ---- outputs while in reset
        #2;
        ds_look(1, 32'h8000_0000, 1, 0);
        check("rst_br", {31'd0, br_taken_pre}, 32'd0);
        check("rst_res", res_cnt, 32'd0);
        check("rst_err", err_cnt, 32'd0);
        ds_look(0, 32'h8000_0000, 0, 1);
        check("rst_jt_pre_jalr", jt_pre, 32'h8000_0004);
        check("rst_jt_hit", {31'd0, jt_hit}, 32'd0);
        ds_look(0, 32'h8000_0000, 0, 0);
        check("rst_jt_pre_nojalr", jt_pre, 32'd0);
        step();
        reset = 1'b0;
        step();

        // ---- cold lookups
        ds_look(1, 32'h8000_0000, 1, 0);
        check("cold_br", {31'd0, br_taken_pre}, 32'd0);
        ds_look(1, 32'h8000_0000, 0, 1);
        check("cold_jt_hit", {31'd0, jt_hit}, 32'd0);
        check("cold_jt_pre", jt_pre, 32'h8000_0004);
        ds_look(0, 32'h8000_0000, 0, 1);
        check("noval_jt_pre", jt_pre, 32'd0);

        // ---- BHT training: 01 -> 10 -> 11
        es_pulse(32'h8000_0010, 1, 0, 1, 32'h0, 0);
        es_pulse(32'h8000_0010, 1, 0, 1, 32'h0, 0);
        ds_look(1, 32'h8000_0010, 1, 0);
        check("bht_taken", {31'd0, br_taken_pre}, 32'd1);
        ds_look(1, 32'h8000_0110, 1, 0);
        check("bht_alias", {31'd0, br_taken_pre}, 32'd1);
        ds_look(0, 32'h8000_0010, 1, 0);
        check("bht_noval", {31'd0, br_taken_pre}, 32'd0);
        ds_look(1, 32'h8000_0010, 1, 0);
        // 11 -> 10 (still taken)
        es_pulse(32'h8000_0010, 1, 0, 0, 32'h0, 0);
        check("bht_nt1", {31'd0, br_taken_pre}, 32'd1);
        // 10 -> 01
        es_pulse(32'h8000_0010, 1, 0, 0, 32'h0, 0);
        check("bht_nt2", {31'd0, br_taken_pre}, 32'd0);
        // 01 -> 00
        es_pulse(32'h8000_0010, 1, 0, 0, 32'h0, 0);
        check("bht_nt3", {31'd0, br_taken_pre}, 32'd0);
        // 00 floored; one taken step -> 01
        es_pulse(32'h8000_0110, 1, 0, 0, 32'h0, 0);
        es_pulse(32'h8000_0110, 1, 0, 1, 32'h0, 0);
        check("bht_floor", {31'd0, br_taken_pre}, 32'd0);
        // 01 -> 10
        es_pulse(32'h8000_0110, 1, 0, 1, 32'h0, 0);
        check("bht_rise", {31'd0, br_taken_pre}, 32'd1);

        // ---- BTB
        es_pulse(32'h8000_0020, 0, 1, 0, 32'h8000_1000, 0);
        ds_look(1, 32'h8000_0020, 0, 1);
        check("btb_hit", {31'd0, jt_hit}, 32'd1);
        check("btb_tgt", jt_pre, 32'h8000_1000);
        ds_look(1, 32'h8000_0060, 0, 1);
        check("btb_tagmiss_hit", {31'd0, jt_hit}, 32'd0);
        check("btb_tagmiss_pre", jt_pre, 32'h8000_0064);

        // ---- branch+jalr together: BHT only
        es_pulse(32'h8000_0040, 1, 1, 1, 32'h8000_5000, 0);
        ds_look(1, 32'h8000_0040, 0, 1);
        check("both_btb_hit", {31'd0, jt_hit}, 32'd0);
        check("both_btb_pre", jt_pre, 32'h8000_0044);
        ds_look(1, 32'h8000_0040, 1, 0);
        check("both_bht", {31'd0, br_taken_pre}, 32'd1);

        // ---- same-cycle update/lookup: no bypass
        es_pulse(32'h8000_0030, 0, 1, 0, 32'h8000_2000, 0);
        es_valid = 1; es_pc = 32'h8000_0030; es_jalr = 1; bj_addr = 32'h8000_3000;
        ds_look(1, 32'h8000_0030, 0, 1);
        check("same_old_hit", {31'd0, jt_hit}, 32'd1);
        check("same_old_tgt", jt_pre, 32'h8000_2000);
        step();
        es_valid = 0; es_jalr = 0;
        #1;
        check("same_new_tgt", jt_pre, 32'h8000_3000);

        // ---- reset clears tables and counters
        do_reset();
        ds_look(1, 32'h8000_0110, 1, 0);
        check("clr_bht", {31'd0, br_taken_pre}, 32'd0);
        ds_look(1, 32'h8000_0030, 0, 1);
        check("clr_btb_hit", {31'd0, jt_hit}, 32'd0);
        check("clr_btb_pre", jt_pre, 32'h8000_0034);
        check("clr_res", res_cnt, 32'd0);

        // ---- counters: 5 resolutions, 2 mispredicts
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        exp_q.push_back(32'd3); exp_q.push_back(32'd1);
        exp_q.push_back(32'd4); exp_q.push_back(32'd2);
        exp_q.push_back(32'd5); exp_q.push_back(32'd2);
        exp_q.push_back(32'd5); exp_q.push_back(32'd2);
        es_pulse(32'h8000_0010, 1, 0, 1, 32'h0, 0);
        check("cnt1_res", res_cnt, exp_q.pop_front());
        check("cnt1_err", err_cnt, exp_q.pop_front());
        es_pulse(32'h8000_0020, 0, 1, 0, 32'h8000_1000, 1);
        check("cnt2_res", res_cnt, exp_q.pop_front());
        check("cnt2_err", err_cnt, exp_q.pop_front());
        es_pulse(32'h8000_0010, 1, 0, 1, 32'h0, 0);
        check("cnt3_res", res_cnt, exp_q.pop_front());
        check("cnt3_err", err_cnt, exp_q.pop_front());
        es_pulse(32'h8000_0050, 1, 0, 0, 32'h0, 1);
        check("cnt4_res", res_cnt, exp_q.pop_front());
        check("cnt4_err", err_cnt, exp_q.pop_front());
        es_pulse(32'h8000_0020, 0, 1, 0, 32'h8000_1000, 0);
        check("cnt5_res", res_cnt, exp_q.pop_front());
        check("cnt5_err", err_cnt, exp_q.pop_front());
        // es_valid low: nothing counts
        es_branch = 1; pre_error = 1;
        step();
        es_branch = 0; pre_error = 0;
        check("cnt_idle_res", res_cnt, exp_q.pop_front());
        check("cnt_idle_err", err_cnt, exp_q.pop_front());
        ds_look(1, 32'h8000_0010, 1, 0);
        check("pre_mid_bht", {31'd0, br_taken_pre}, 32'd1);
        ds_look(1, 32'h8000_0020, 0, 1);
        check("pre_mid_btb", {31'd0, jt_hit}, 32'd1);

        // ---- asynchronous reset in the middle of an update
        es_valid = 1; es_pc = 32'h8000_0010; es_branch = 1; b_taken_real = 1; pre_error = 1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_res", res_cnt, 32'd0);
        check("mid_err", err_cnt, 32'd0);
        check("mid_btb_hit", {31'd0, jt_hit}, 32'd0);
        ds_look(1, 32'h8000_0010, 1, 0);
        check("mid_bht", {31'd0, br_taken_pre}, 32'd0);
        es_valid = 0; es_branch = 0; pre_error = 0;
        #1;
        reset = 1'b0;
        step();
        check("post_mid_res", res_cnt, 32'd0);
        check("post_mid_bht", {31'd0, br_taken_pre}, 32'd0);

`ifdef YSYX_22041752_RAS_EN
        // ---- return address stack
        do_reset();
        ds_valid = 1; ds_ready_go = 1; ds_pc = 32'h8000_0100; ds_call = 1;
        ds_branch = 0; ds_jalr = 0;
        step();
        ds_call = 0; ds_ret = 1; ds_jalr = 1; ds_pc = 32'h8000_0300;
        #1;
        check("ras_one_hit", {31'd0, jt_hit}, 32'd1);
        check("ras_one_pre", jt_pre, 32'h8000_0104);
        step();
        ds_ret = 0; ds_jalr = 0;
        for (int i = 0; i < 5; i++) begin
            ds_call = 1;
            ds_pc   = 32'h8000_0100 + 32'h10 * i;
            step();
        end
        ds_call = 0;
        exp_q.push_back(32'h8000_0144);
        exp_q.push_back(32'h8000_0134);
        exp_q.push_back(32'h8000_0124);
        exp_q.push_back(32'h8000_0114);
        ds_ret = 1; ds_jalr = 1; ds_pc = 32'h8000_0300;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ras_pop_hit", {31'd0, jt_hit}, 32'd1);
            check("ras_pop_pre", jt_pre, exp_q.pop_front());
            step();
        end
        #1;
        check("ras_empty_hit", {31'd0, jt_hit}, 32'd0);
        check("ras_empty_pre", jt_pre, 32'h8000_0304);
        ds_ret = 0; ds_jalr = 0; ds_valid = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pre.md
Name: branch_pre

Overview:
- Prediction side of the execute-stage branch/jump resolver in the ysyx_22041752 core.
- Sits in decode. Produces br_taken_pre and jt_pre, which travel down the pipe with the instruction.
- Trains its tables from the execute-stage resolution: real outcome, computed target, mispredict flag.
- Contents:
  - direct-mapped BHT of 2-bit saturating counters for conditional branches;
  - direct-mapped BTB for jalr targets;
  - two free-running statistics counters.

Parameters:
PC_WD, 32, pc/target width (`ysyx_22041752_PC_WD)
BHT_IDX, 6, log2 BHT entries (64)
BTB_IDX, 4, log2 BTB entries (16)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
ds_valid  input  1  decode holds a valid instruction
ds_ready_go  input  1  decode instruction leaves this cycle (used only by the optional RAS)
ds_pc  input  PC_WD  decode pc
ds_branch  input  1  decode instruction is a conditional branch
ds_jalr  input  1  decode instruction is jalr
br_taken_pre  output  1  predicted taken for ds branch
jt_pre  output  PC_WD  predicted jalr target
jt_hit  output  1  BTB hit for ds jalr
es_valid  input  1  one-cycle pulse per resolved instruction in execute
es_pc  input  PC_WD  execute pc
es_branch  input  1  resolved instruction is a branch
es_jalr  input  1  resolved instruction is jalr
b_taken_real  input  1  real branch outcome
bj_addr  input  PC_WD  computed branch/jump target
pre_error  input  1  execute-detected mispredict
res_cnt  output  32  resolved branch+jalr count
err_cnt  output  32  mispredict count

Behaviour:
- Lookup is combinational from registered tables. No lookup latency; a table write is visible from the cycle after es_valid.
- BHT index: pc[BHT_IDX+1:2]. br_taken_pre = ds_valid & ds_branch & bht[idx][1]; 0 otherwise.
- BHT update on es_valid & es_branch:
  - b_taken_real=1: counter saturating +1, capped at 2'b11;
  - b_taken_real=0: counter saturating -1, floored at 2'b00.
- BTB entry: {valid, tag=pc[PC_WD-1:BTB_IDX+2], target}. Index: pc[BTB_IDX+1:2].
- BTB lookup, when ds_valid & ds_jalr:
  - hit (valid & tag match): jt_hit=1, jt_pre=target;
  - miss: jt_hit=0, jt_pre=ds_pc+4.
- When not ds_valid & ds_jalr: jt_hit=0, jt_pre=0.
- BTB update on es_valid & es_jalr: entry at es_pc index <= {1, es tag, bj_addr}. Unconditional overwrite, direct-mapped replacement.
- Same-cycle lookup and update of the same entry: lookup returns the pre-update value. No bypass.
- es_branch and es_jalr are mutually exclusive. If both are asserted, only the BHT is updated.
- res_cnt increments on es_valid & (es_branch|es_jalr). err_cnt increments on es_valid & pre_error. Both wrap 0xFFFFFFFF->0.
- Reset, asynchronous, takes effect immediately including mid-update:
  - all BHT counters = 2'b01 (weakly not-taken);
  - all BTB valid = 0;
  - res_cnt = err_cnt = 0.
- Output values during reset: br_taken_pre=0, jt_hit=0, jt_pre=0 if ds_jalr is low, else ds_pc+4.
- es_valid held high for N cycles updates N times; the pipeline guarantees a single-cycle pulse.

Optional Feature:
- Macro: YSYX_22041752_RAS_EN.
- Defined: adds input ports ds_call and ds_ret and a 4-entry return address stack.
- Push, on ds_valid & ds_ready_go & ds_call: push ds_pc+4. Full stack overwrites the oldest entry (circular pointer).
- Pop, on ds_valid & ds_ready_go & ds_ret with a non-empty stack: pop.
- Override, while ds_valid & ds_jalr & ds_ret with a non-empty stack: jt_pre = top-of-stack, jt_hit=1, BTB ignored. This applies combinationally in the same cycle.
- Empty stack: falls back to the BTB.
- Push and pop in the same cycle: replace top. Reset empties the stack.
- The stack is not repaired on pre_error.
- Undefined: no ports ds_call/ds_ret, no stack; jalr prediction is BTB-only.

Test Plan:
- After reset, ds_branch at pc 0x80000000 -> br_taken_pre=0; jalr at the same pc -> jt_hit=0, jt_pre=0x80000004.
- Two es_valid branch pulses at es_pc 0x80000010, b_taken_real=1 -> next cycle ds_pc 0x80000010 branch gives br_taken_pre=1. Three not-taken updates -> 0. Sixty-four-entry alias pc 0x80000110 shares the counter.
- es jalr at 0x80000020, bj_addr 0x80001000 -> ds jalr 0x80000020: jt_hit=1, jt_pre=0x80001000. Same index with different tag (0x80000060) -> miss, jt_pre=0x80000064.
- Same-cycle BTB update and lookup at 0x80000030 -> lookup shows the old contents; the following cycle shows the new target.
- 5 resolutions, 2 with pre_error=1 -> res_cnt=5, err_cnt=2. Assert reset mid-sequence -> both 0 and tables cleared asynchronously.
- With YSYX_22041752_RAS_EN: call at 0x80000100 then ret -> jt_pre=0x80000104. Five calls then five rets -> first four pops return the latest four addresses, the fifth falls back to the BTB.
